// File: rtl/video_capture_pkg.sv
// Shared types and widths for the video_capture_axis front end.
// FIFO word layout is {tuser, tlast, tdata}.
package video_capture_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitLine,
    StActive,
    StDrop
  } cap_state_e;

  localparam int unsigned CNT_W = 12;
  localparam int unsigned FRM_W = 16;
  localparam int unsigned SB_W  = 2;

  function automatic int unsigned word_w(input int unsigned data_w);
    return data_w + SB_W;
  endfunction

endpackage

// File: rtl/video_capture_axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with async-reset pointers.
// A write while full succeeds when a read frees a slot in the same cycle.
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd      = i_rd_en && !o_empty;
  assign w_wr      = i_wr_en && (!o_full || w_rd);
  assign o_rd_data = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/video_capture_axis.sv
// DVP (href/vsync/data) to AXI4-Stream capture with FIFO back-pressure and error flags.
// Define CAPTURE_TPG_EN to add tpg_sel, which replaces pixels with the column count.
module video_capture_axis
  import video_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          VSYNC_POL  = 1'b1,
  parameter bit          HREF_POL   = 1'b1
) (
  input  logic                  piexl_clk,
  input  logic                  rst,
  input  logic                  href,
  input  logic                  vsync,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  enable,
`ifdef CAPTURE_TPG_EN
  input  logic                  tpg_sel,
`endif
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  overflow,
  output logic                  line_err,
  output logic [FRM_W-1:0]      frame_cnt,
  input  logic                  clr_status
);

  localparam int unsigned WORD_W = word_w(DATA_WIDTH);

  cap_state_e            r_state, w_state_d;
  logic                  r_href, r_vsync, r_vsync_q;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_W-1:0]      r_pix_cnt, r_line_cnt;
  logic [FRM_W-1:0]      r_frame_cnt;
  logic                  r_hold_vld, r_hold_last;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_sof, r_ovf, r_lerr;

  logic                  w_vs_edge, w_in_line, w_accept, w_keep, w_extra;
  logic                  w_line_end, w_short, w_wr_last, w_ovf, w_wr_ok;
  logic                  w_full, w_empty, w_rd, w_frame_done;
  logic [DATA_WIDTH-1:0] w_pix;
  logic [WORD_W-1:0]     w_wr_word, w_rd_word;

  assign w_vs_edge    = r_vsync && !r_vsync_q;
  assign w_in_line    = (r_state == StWaitLine) || (r_state == StActive);
  assign w_accept     = w_in_line && r_href && !w_vs_edge;
  assign w_keep       = w_accept && (r_pix_cnt < CNT_W'(IMG_WIDTH));
  assign w_extra      = w_accept && !w_keep;
  assign w_line_end   = (r_state == StActive) && !r_href;
  assign w_short      = w_line_end && (r_pix_cnt != CNT_W'(IMG_WIDTH));
  // The held pixel is the last of its line if its count says so or href just dropped.
  assign w_wr_last    = r_hold_last || w_line_end;
  assign w_rd         = !w_empty && m_axis_tready;
  assign w_ovf        = r_hold_vld && w_full && !w_rd;
  assign w_wr_ok      = r_hold_vld && !w_ovf;
  assign w_frame_done = w_vs_edge && w_in_line && (r_line_cnt == CNT_W'(IMG_HEIGHT));
  assign w_wr_word    = {r_sof, w_wr_last, r_hold_data};

`ifdef CAPTURE_TPG_EN
  assign w_pix = tpg_sel ? DATA_WIDTH'(r_pix_cnt) : r_data;
`else
  assign w_pix = r_data;
`endif

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:     if (w_vs_edge && enable) w_state_d = StWaitLine;
      StWaitLine: begin
        if (w_vs_edge)   w_state_d = enable ? StWaitLine : StIdle;
        else if (r_href) w_state_d = StActive;
      end
      StActive: begin
        if (w_vs_edge)    w_state_d = enable ? StWaitLine : StIdle;
        else if (!r_href) w_state_d = StWaitLine;
      end
      StDrop:     if (w_vs_edge) w_state_d = enable ? StWaitLine : StIdle;
      default:    w_state_d = StIdle;
    endcase
    if (w_ovf) w_state_d = StDrop;
  end

  always_ff @(posedge piexl_clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_href      <= 1'b0;
      r_vsync     <= 1'b0;
      r_vsync_q   <= 1'b0;
      r_data      <= '0;
      r_pix_cnt   <= '0;
      r_line_cnt  <= '0;
      r_frame_cnt <= '0;
      r_hold_vld  <= 1'b0;
      r_hold_last <= 1'b0;
      r_hold_data <= '0;
      r_sof       <= 1'b0;
      r_ovf       <= 1'b0;
      r_lerr      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_href      <= (href == HREF_POL);
      r_vsync     <= (vsync == VSYNC_POL);
      r_vsync_q   <= r_vsync;
      r_data      <= data_in;
      // Saturates at IMG_WIDTH so over-long lines keep being rejected.
      if (w_keep)         r_pix_cnt <= r_pix_cnt + 1'b1;
      else if (!w_accept) r_pix_cnt <= '0;
      if (w_vs_edge)       r_line_cnt <= '0;
      else if (w_line_end) r_line_cnt <= r_line_cnt + 1'b1;
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 1'b1;
      r_hold_vld  <= w_keep && !w_ovf;
      r_hold_last <= (r_pix_cnt == CNT_W'(IMG_WIDTH - 1));
      r_hold_data <= w_pix;
      if (w_vs_edge)    r_sof <= 1'b1;
      else if (w_wr_ok) r_sof <= 1'b0;
      r_ovf  <= w_ovf || (r_ovf && !clr_status);
      r_lerr <= w_extra || w_short || (r_lerr && !clr_status);
    end
  end

  axis_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (piexl_clk),
    .i_rst     (rst),
    .i_wr_en   (w_wr_ok),
    .i_wr_data (w_wr_word),
    .o_full    (w_full),
    .i_rd_en   (m_axis_tready),
    .o_rd_data (w_rd_word),
    .o_empty   (w_empty)
  );

  always_comb begin
    m_axis_tvalid = !w_empty;
    {m_axis_tuser, m_axis_tlast, m_axis_tdata} = w_empty ? '0 : w_rd_word;
  end

  assign overflow  = r_ovf;
  assign line_err  = r_lerr;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_video_capture_axis.sv
// Randomised bench for video_capture_axis: frame-level reference model feeds a scoreboard
// queue, and an independent monitor checks every AXI4-Stream beat and stall.
module tb_video_capture_axis;

  localparam int DW = 10;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int D  = 16;

  localparam int RdyOn     = 0;
  localparam int RdyToggle = 1;
  localparam int RdyRand   = 2;
  localparam int RdyOff    = 3;

  logic          clk = 1'b0;
  logic          rst, href, vsync, enable, tready, clr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] tdata;
  logic          tvalid, tuser, tlast, overflow, line_err;
  logic [15:0]   frame_cnt;

  int            n_asserts = 0;
  int            n_fail    = 0;
  int            ready_mode = RdyOn;

  // Reference model state
  logic [DW+1:0] exp_q [$];
  bit            m_cap, m_drop, m_sof, m_ovf, m_lerr;
  int            m_lines, m_frames;

  always #5 clk = ~clk;

  video_capture_axis #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .FIFO_DEPTH (D),
    .VSYNC_POL  (1'b1),
    .HREF_POL   (1'b1)
  ) dut (
    .piexl_clk     (clk),
    .rst           (rst),
    .href          (href),
    .vsync         (vsync),
    .data_in       (data_in),
    .enable        (enable),
`ifdef CAPTURE_TPG_EN
    .tpg_sel       (1'b0),
`endif
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tuser  (tuser),
    .m_axis_tlast  (tlast),
    .overflow      (overflow),
    .line_err      (line_err),
    .frame_cnt     (frame_cnt),
    .clr_status    (clr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_asserts++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_vsync();
    vsync = 1'b1;
    if (m_cap && !m_drop && m_lines == H) m_frames++;
    m_lines = 0;
    m_cap   = enable;
    m_drop  = 1'b0;
    m_sof   = 1'b1;
    repeat (2) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic m_line(input int n);
    for (int i = 0; i < n; i++) begin
      href    = 1'b1;
      data_in = DW'($urandom);
      if (m_cap && !m_drop) begin
        if (i >= W) begin
          m_lerr = 1'b1;
        end else if (ready_mode == RdyOff && exp_q.size() >= D) begin
          m_drop = 1'b1;
          m_ovf  = 1'b1;
        end else begin
          exp_q.push_back({m_sof, (i == W - 1) || (n < W && i == n - 1), data_in});
          m_sof = 1'b0;
        end
      end
      tick();
    end
    href = 1'b0;
    if (m_cap && !m_drop) begin
      m_lines++;
      if (n < W) m_lerr = 1'b1;
    end
    repeat (3) tick();
  endtask

  task automatic frame(input int a, input int b, input int c);
    m_vsync();
    m_line(a);
    m_line(b);
    m_line(c);
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      tick();
      t++;
    end
    check({nm, "_pending"}, exp_q.size(), 0);
    repeat (4) tick();
    check({nm, "_tvalid"}, tvalid, 1'b0);
  endtask

  task automatic check_flags(input string nm);
    check({nm, "_overflow"}, overflow, m_ovf);
    check({nm, "_line_err"}, line_err, m_lerr);
    check({nm, "_frame_cnt"}, frame_cnt, m_frames);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_ovf  = 1'b0;
    m_lerr = 1'b0;
    tick();
  endtask

  // Back-pressure pattern
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        RdyOn:     tready = 1'b1;
        RdyToggle: tready = ~tready;
        RdyRand:   tready = 1'($urandom_range(0, 1));
        default:   tready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pop on each transfer, stability check on each stall
  initial begin
    logic          p_valid = 1'b0;
    logic          p_ready = 1'b0;
    logic [DW+1:0] p_word  = '0;
    logic [DW+1:0] act;
    forever begin
      @(negedge clk);
      act = {tuser, tlast, tdata};
      if (rst) begin
        p_valid = 1'b0;
      end else begin
        if (p_valid && !p_ready) begin
          check("stall_valid", tvalid, 1'b1);
          check("stall_word", act, p_word);
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            n_asserts++;
            n_fail++;
            $display("FAIL unexpected_beat: actual %0h required no beat at %0t", act, $time);
          end else begin
            check("beat", act, exp_q.pop_front());
          end
        end
        p_valid = tvalid;
        p_ready = tready;
        p_word  = act;
      end
    end
  end

  initial begin
    rst = 1'b1; href = 1'b0; vsync = 1'b0; enable = 1'b1; clr = 1'b0; data_in = '0;
    m_cap = 0; m_drop = 0; m_sof = 0; m_ovf = 0; m_lerr = 0; m_lines = 0; m_frames = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser", tuser, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check_flags("rst");
    rst = 1'b0;
    repeat (2) tick();

    // Nominal 4x3
    ready_mode = RdyOn;
    frame(4, 4, 4);
    m_vsync();
    drain("nominal");
    check_flags("nominal");

    // Toggling and random back-pressure
    ready_mode = RdyToggle;
    frame(4, 4, 4);
    m_vsync();
    drain("toggle");
    ready_mode = RdyRand;
    frame(4, 4, 4);
    frame(4, 4, 4);
    m_vsync();
    drain("random");
    check_flags("backpressure");

    // Short and long lines
    ready_mode = RdyOn;
    frame(3, 6, 4);
    m_vsync();
    drain("linelen");
    check_flags("linelen");
    clr_pulse();
    check_flags("clr");

    // Overflow: stall a full frame, then overflow the next one
    ready_mode = RdyOff;
    repeat (3) tick();
    frame(4, 4, 4);
    frame(4, 4, 4);
    check("ovf_stalled", overflow, m_ovf);
    ready_mode = RdyOn;
    drain("overflow");
    check_flags("overflow");
    frame(4, 4, 4);
    m_vsync();
    drain("recover");
    check_flags("recover");
    clr_pulse();

    // Enable dropped mid-frame, then raised mid-frame
    ready_mode = RdyRand;
    m_vsync();
    m_line(4);
    enable = 1'b0;
    m_line(4);
    m_line(4);
    m_vsync();
    m_line(4);
    enable = 1'b1;
    m_line(4);
    m_line(4);
    frame(4, 4, 4);
    m_vsync();
    drain("enable");
    check_flags("enable");

    // Reset mid-line
    ready_mode = RdyOn;
    m_vsync();
    href = 1'b1;
    data_in = DW'($urandom);
    tick();
    data_in = DW'($urandom);
    tick();
    rst = 1'b1;
    href = 1'b0;
    exp_q.delete();
    m_cap = 0; m_drop = 0; m_sof = 0; m_ovf = 0; m_lerr = 0; m_lines = 0; m_frames = 0;
    #1;
    check("midrst_tvalid", tvalid, 1'b0);
    check("midrst_frame_cnt", frame_cnt, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    frame(4, 4, 4);
    m_vsync();
    drain("postrst");
    check_flags("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/video_capture_axis.md
Name: video_capture_axis

Overview:
- Parametrised successor to the DVP capture front end.
- Converts camera parallel video (href/vsync/data) into AXI4-Stream video with real tready back-pressure through an internal FIFO.
- Enforces line length, gates capture to whole frames, and reports overflow and line-length errors.
- Sits between the sensor pins and the VDMA/ISP input.

Parameters:
- DATA_WIDTH, 10, pixel width in bits.
- IMG_WIDTH, 640, expected active pixels per line (2..4095).
- IMG_HEIGHT, 480, expected lines per frame (1..4095).
- FIFO_DEPTH, 16, output FIFO entries (power of 2, >=4).
- VSYNC_POL, 1, active level of vsync.
- HREF_POL, 1, active level of href.

Ports:
- piexl_clk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- href  in  1  line valid (polarity HREF_POL).
- vsync  in  1  frame sync (polarity VSYNC_POL).
- data_in  in  DATA_WIDTH  pixel data.
- enable  in  1  capture request; honoured only at frame boundaries.
- m_axis_tdata  out  DATA_WIDTH  pixel.
- m_axis_tvalid  out  1  FIFO not empty.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  first pixel of frame.
- m_axis_tlast  out  1  last pixel of line.
- overflow  out  1  sticky; FIFO full on a write.
- line_err  out  1  sticky; a line was not exactly IMG_WIDTH pixels.
- frame_cnt  out  16  completed frames, wraps at 0xFFFF.
- clr_status  in  1  synchronous clear of overflow and line_err.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, counters 0.
- Input stage: href, vsync and data_in are registered once and normalised to active-high.
- A second holding register delays each pixel by one more cycle so that tlast can be attached when href falls.
- Pin-to-FIFO-write latency: 2 cycles. FIFO-to-output: first-word-fall-through, 0 cycles.
- FSM states:
  - IDLE: waits for a vsync active edge with enable=1, then goes to WAIT_LINE.
  - WAIT_LINE: href active moves to ACTIVE; vsync active moves to WAIT_LINE (abort path); enable=0 at vsync moves to IDLE.
  - ACTIVE: counts pixels; href inactive moves to WAIT_LINE with line_cnt+1.
  - DROP: discards pixels until the next vsync active edge, then goes to WAIT_LINE (or IDLE if enable=0).
- Frame completion: at the next vsync active edge with line_cnt==IMG_HEIGHT, frame_cnt increments and line_cnt resets to 0.
- tuser: set on the first written pixel after a vsync edge; cleared after that write.
- tlast, pixel count 12-bit, resets per line:
  - Set on the pixel with count==IMG_WIDTH-1.
  - Set on the held pixel when href falls early (short line); line_err is set.
  - Pixels beyond IMG_WIDTH are not written; line_err is set.
- Handshake:
  - A beat transfers when tvalid && tready.
  - tdata, tuser and tlast stay stable while tvalid && !tready.
- FIFO full on a pending write:
  - The pixel is dropped and overflow is set.
  - FSM enters DROP, so no partial frame is emitted past the fault; already-queued beats still drain.
- Simultaneous write and read while full: the read frees a slot, so the write succeeds and there is no overflow.
- clr_status and a new error in the same cycle: the error wins, flag stays 1.
- enable deasserted mid-frame: the current frame completes; the FSM returns to IDLE at the next vsync.
- Reset mid-frame: FIFO is flushed immediately, outputs go to 0, and the FSM waits for a fresh vsync.

Optional Feature:
- Macro: CAPTURE_TPG_EN.
- When defined:
  - Adds input port tpg_sel (1 bit).
  - When tpg_sel=1, pixel data is replaced by the column count (low DATA_WIDTH bits, zero-extended); all timing and flags are unchanged.
- When undefined: no port, no mux; data_in passes through.

Decomposition:
- Package video_capture_pkg holds:
  - FSM state enum (IDLE, WAIT_LINE, ACTIVE, DROP).
  - Counter width constant CNT_W=12 and frame counter width FRM_W=16.
  - FIFO word layout {tuser, tlast, tdata}, width DATA_WIDTH+2.
- One sub-module, axis_sync_fifo:
  - Single-clock, first-word-fall-through, parametrised width and depth.
  - Provides full/empty and async-reset pointers.

Test Plan:
- Nominal: 4x3 frame (IMG_WIDTH=4, IMG_HEIGHT=3), tready=1 → 12 beats; tuser on beat 0 only; tlast on beats 3, 7, 11; frame_cnt=1 after the next vsync.
- Back-pressure: tready toggles 1/0 each cycle, FIFO_DEPTH=16 → all 12 beats delivered in order, data stable while stalled, overflow=0.
- Overflow: tready=0 for a 640-pixel line, FIFO_DEPTH=16 → 16 beats queued, overflow=1, no further writes until the next vsync; the next frame is captured normally.
- Line length errors:
  - Short line of 3 pixels with IMG_WIDTH=4 → tlast on the 3rd pixel, line_err=1.
  - Long line of 6 pixels → 4 beats, tlast on the 4th, line_err=1.
  - clr_status pulse → line_err=0.
- Enable gating: enable raised mid-frame → no beats until the next vsync; enable dropped mid-frame → the current frame completes, then no output.
- Reset mid-line: rst pulse after 2 pixels → tvalid=0 and frame_cnt=0 immediately; the next full frame starts with tuser=1.
